// File: rtl/string_scan.sv
// Column scanner for a packed character string feeding a font ROM / LED driver.
// Optional leading-space skipping is enabled by defining STRING_SCAN_SKIP_BLANK_EN.
module string_scan #(
  parameter int NCHARS = 11,
  parameter int CW     = 7,
  parameter int COLS   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NCHARS*CW-1:0] str,
  input  logic                 ready,
  output logic                 valid,
  output logic [CW-1:0]        char,
  output logic [3:0]           char_idx,
  output logic [2:0]           col,
  output logic                 gap,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_COL = 3'(COLS);
  localparam logic [3:0] LAST_IDX = 4'(NCHARS - 1);

  state_t               state_r;
  logic [NCHARS*CW-1:0] snap_r;
  logic [CW-1:0]        next_char_s;

  // Character idx of a packed string; char 0 sits in the most significant slot.
  function automatic logic [CW-1:0] char_at(input logic [NCHARS*CW-1:0] s,
                                            input logic [3:0]           idx);
    logic [NCHARS*CW-1:0] sh;
    sh = s << (idx * CW);
    return sh[NCHARS*CW-1 -: CW];
  endfunction

`ifdef STRING_SCAN_SKIP_BLANK_EN
  function automatic logic is_blank(input logic [CW-1:0] c);
    return c == CW'(7'h20);
  endfunction
`endif

  // Character that follows the current one in the snapshot.
  always_comb begin
    next_char_s = char_at(snap_r, char_idx + 4'd1);
  end

  // Scan state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      snap_r   <= {(NCHARS*CW){1'b0}};
      valid    <= 1'b0;
      char     <= {CW{1'b0}};
      char_idx <= 4'd0;
      col      <= 3'd0;
      gap      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          gap  <= 1'b0;
          if (start) begin
            state_r  <= SEND;
            snap_r   <= str;
            busy     <= 1'b1;
            char_idx <= 4'd0;
            col      <= 3'd0;
            char     <= char_at(str, 4'd0);
`ifdef STRING_SCAN_SKIP_BLANK_EN
            valid    <= !is_blank(char_at(str, 4'd0));
`else
            valid    <= 1'b1;
`endif
          end else begin
            valid <= 1'b0;
            busy  <= 1'b0;
          end
        end
        SEND: begin
          if (valid && ready) begin
            if (col != LAST_COL) begin
              col <= col + 3'd1;
              gap <= (col + 3'd1) == LAST_COL;
            end else if (char_idx != LAST_IDX) begin
              char_idx <= char_idx + 4'd1;
              col      <= 3'd0;
              gap      <= 1'b0;
              char     <= next_char_s;
            end else begin
              state_r <= DONE;
              valid   <= 1'b0;
              gap     <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
`ifdef STRING_SCAN_SKIP_BLANK_EN
          // valid is only low in SEND while stepping over leading spaces.
          else if (!valid) begin
            if (char_idx == LAST_IDX) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              char_idx <= char_idx + 4'd1;
              char     <= next_char_s;
              valid    <= !is_blank(next_char_s);
            end
          end
`endif
          else begin
            state_r <= SEND;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          valid   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          gap     <= 1'b0;
        end
      endcase
    end
  end

endmodule
